// File: rtl/led_counter_mux.sv
// led_counter_mux: prescaled BCD up/down counter with load, wrap carry and multiplexed 7-segment drive
module led_counter_mux #(
    parameter int DIGITS         = 2,
    parameter int TICK_DIV       = 50_000_000,
    parameter int SCAN_DIV       = 50_000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                div_rst_i,
    input  logic                e_i,
    input  logic                u_i,
    input  logic                ld_i,
    input  logic [4*DIGITS-1:0] ld_val_i,
    output logic                tick_o,
    output logic [4*DIGITS-1:0] count_o,
    output logic                carry_o,
    output logic [DIGITS-1:0]   seg_sel_o,
    output logic [6:0]          seg_o
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [TW-1:0]       tick_q, tick_d;
    logic [SW-1:0]       scan_q, scan_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic                carry_q, carry_d;
    logic                scan_end, ripple, upper_zero, blank;
    logic [3:0]          nib, digit;
    logic [6:0]          enc;

    assign tick_o    = !div_rst_i && (tick_q == TW'(TICK_DIV - 1));
    assign scan_end  = !div_rst_i && (scan_q == SW'(SCAN_DIV - 1));
    assign count_o   = count_q;
    assign carry_o   = carry_q;
    assign seg_sel_o = DIGITS'(1) << idx_q;
    assign blank     = (BLANK_LZ != 0) && (idx_q != '0) && upper_zero;
    assign seg_o     = (blank ? 7'd0 : enc) ^ {7{SEG_ACTIVE_LOW != 0}};

    // Prescalers wrap on terminal count; DivRst parks both at zero without touching the scan index
    always_comb begin
        tick_d = (div_rst_i || tick_o) ? '0 : tick_q + 1'b1;
        scan_d = (div_rst_i || scan_end) ? '0 : scan_q + 1'b1;
        idx_d  = !scan_end ? idx_q : (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // Count next state: load (clamped to 9 per digit) beats a BCD step; a ripple out of the top digit is the wrap
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        ripple  = 1'b0;
        nib     = '0;
        if (ld_i) begin
            for (int d = 0; d < DIGITS; d++) begin
                nib = ld_val_i[4*d +: 4];
                count_d[4*d +: 4] = (nib > 4'd9) ? 4'd9 : nib;
            end
        end else if (tick_o && e_i) begin
            ripple = 1'b1;
            for (int d = 0; d < DIGITS; d++) begin
                nib = count_q[4*d +: 4];
                if (ripple) begin
                    count_d[4*d +: 4] = u_i ? ((nib == 4'd9) ? 4'd0 : nib + 1'b1)
                                            : ((nib == 4'd0) ? 4'd9 : nib - 1'b1);
                    ripple = u_i ? (nib == 4'd9) : (nib == 4'd0);
                end
            end
            carry_d = ripple;
        end
    end

    // All state registers, cleared immediately by Rst
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q  <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    // Pick the scanned digit and find whether it and every higher digit are zero
    always_comb begin
        digit      = count_q[4*idx_q +: 4];
        upper_zero = 1'b1;
        for (int d = 0; d < DIGITS; d++)
            if (IW'(d) >= idx_q && count_q[4*d +: 4] != 4'd0) upper_zero = 1'b0;
    end

    // Active-high segment encoding {CA..CG}
    always_comb begin
        case (digit)
            4'd0:    enc = 7'b1111110;
            4'd1:    enc = 7'b0110000;
            4'd2:    enc = 7'b1101101;
            4'd3:    enc = 7'b1111001;
            4'd4:    enc = 7'b0110011;
            4'd5:    enc = 7'b1011011;
            4'd6:    enc = 7'b1011111;
            4'd7:    enc = 7'b1110000;
            4'd8:    enc = 7'b1111111;
            default: enc = 7'b1111011;
        endcase
    end
endmodule

// File: tb/tb_led_counter_mux.sv
// tb_led_counter_mux: table vectors, corner sequences and random stimulus against a decimal reference model
module tb_led_counter_mux;
    localparam int TD = 4;
    localparam int SD = 3;

    logic       clk = 1'b0;
    logic       rst, div_rst, e, u, ld;
    logic [7:0] ld_val;
    logic       tick, carry, tick_b, carry_b;
    logic [7:0] count, count_b;
    logic [1:0] sel, sel_b;
    logic [6:0] seg, seg_b;
    bit         chk_en = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    led_counter_mux #(.DIGITS(2), .TICK_DIV(TD), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(0), .BLANK_LZ(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .div_rst_i(div_rst), .e_i(e), .u_i(u), .ld_i(ld), .ld_val_i(ld_val),
        .tick_o(tick), .count_o(count), .carry_o(carry), .seg_sel_o(sel), .seg_o(seg));

    led_counter_mux #(.DIGITS(2), .TICK_DIV(TD), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(0), .BLANK_LZ(1)) u_blk (
        .clk_i(clk), .rst_i(rst), .div_rst_i(div_rst), .e_i(e), .u_i(u), .ld_i(ld), .ld_val_i(ld_val),
        .tick_o(tick_b), .count_o(count_b), .carry_o(carry_b), .seg_sel_o(sel_b), .seg_o(seg_b));

    // Reference model: count held as a plain decimal integer 0..99
    logic [6:0] enc_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    int   m_val, m_phase, m_scan, m_idx;
    bit   m_carry;
    logic m_tick;
    assign m_tick = !div_rst && (m_phase == TD - 1);

    function automatic int ld_dec(input logic [7:0] v);
        int lo, hi;
        lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_val <= 0; m_phase <= 0; m_scan <= 0; m_idx <= 0; m_carry <= 1'b0;
        end else begin
            m_phase <= div_rst ? 0 : (m_phase + 1) % TD;
            m_scan  <= div_rst ? 0 : (m_scan + 1) % SD;
            if (!div_rst && m_scan == SD - 1) m_idx <= (m_idx + 1) % 2;
            m_carry <= !ld && m_tick && e && (u ? m_val == 99 : m_val == 0);
            if (ld) m_val <= ld_dec(ld_val);
            else if (m_tick && e) m_val <= u ? (m_val + 1) % 100 : (m_val + 99) % 100;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int dg;
            dg = (m_idx == 1) ? m_val / 10 : m_val % 10;
            check("tick", 8'(tick), 8'(m_tick));
            check("count", count, to_bcd(m_val));
            check("carry", 8'(carry), 8'(m_carry));
            check("segsel", 8'(sel), 8'(1 << m_idx));
            check("seg", 8'(seg), 8'(enc_tbl[dg]));
            check("blk_tick", 8'(tick_b), 8'(m_tick));
            check("blk_count", count_b, to_bcd(m_val));
            check("blk_carry", 8'(carry_b), 8'(m_carry));
            check("blk_segsel", 8'(sel_b), 8'(1 << m_idx));
            check("blk_seg", 8'(seg_b), (m_idx == 1 && m_val < 10) ? 8'd0 : 8'(enc_tbl[dg]));
        end
    end

    task automatic run_ticks(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < n * TD + 20) begin
            @(negedge clk);
            cyc++;
            if (tick === 1'b1) seen++;
        end
        check("tick_budget", 8'(seen), 8'(n));
        @(posedge clk); #2;
    endtask

    task automatic load(input logic [7:0] v);
        ld_val = v; ld = 1'b1;
        @(posedge clk); #2 ld = 1'b0;
    endtask

    typedef struct {
        bit         ld;
        logic [7:0] val;
        bit         e;
        bit         u;
        int         ticks;
        logic [7:0] exp_count;
        bit         exp_carry;
    } vec_t;
    vec_t tbl [13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 10, 8'h10, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 89, 8'h99, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1,  8'h00, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1,  8'h01, 1'b0};
        tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 0,  8'h00, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1,  8'h99, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1,  8'h98, 1'b0};
        tbl[7]  = '{1'b1, 8'h4A, 1'b0, 1'b0, 0,  8'h49, 1'b0};
        tbl[8]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 0,  8'h99, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8,  8'h99, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1,  8'h00, 1'b1};
        tbl[11] = '{1'b1, 8'h5C, 1'b0, 1'b0, 0,  8'h59, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 3,  8'h56, 1'b0};

        rst = 1'b0; div_rst = 1'b0; e = 1'b0; u = 1'b1; ld = 1'b0; ld_val = 8'h00;
        #1 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        chk_en = 1'b1;

        load(8'h37);
        check("pre_rst_count", count, 8'h37);
        rst = 1'b1;
        #1;
        check("rst_count", count, 8'h00);
        check("rst_segsel", 8'(sel), 8'h01);
        check("rst_seg", 8'(seg), 8'(7'b1111110));
        check("rst_carry", 8'(carry), 8'h00);
        check("rst_tick", 8'(tick), 8'h00);
        @(posedge clk); #2 rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].ld) load(tbl[i].val);
            else begin
                e = tbl[i].e; u = tbl[i].u;
                run_ticks(tbl[i].ticks);
            end
            check("tbl_count", count, tbl[i].exp_count);
            check("tbl_carry", 8'(carry), 8'(tbl[i].exp_carry));
        end

        e = 1'b0;
        load(8'h99);
        begin
            int cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (tick !== 1'b1 && cyc < 2 * TD);
            check("ld_tick_wait", 8'(tick), 8'h01);
        end
        ld_val = 8'h20; ld = 1'b1; e = 1'b1; u = 1'b1;
        @(posedge clk); #2 ld = 1'b0; e = 1'b0;
        check("ld_on_tick_count", count, 8'h20);
        check("ld_on_tick_carry", 8'(carry), 8'h00);

        @(posedge clk); #2 div_rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("divrst_tick", 8'(tick), 8'h00);
        end
        @(posedge clk); #2 div_rst = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            check("divrst_release_tick", 8'(tick), 8'(k == 3));
        end

        load(8'h07);
        repeat (12) begin
            @(negedge clk);
            if (sel == 2'b01) begin
                check("scan_lo_seg", 8'(seg), 8'(7'b1110000));
                check("scan_lo_blk", 8'(seg_b), 8'(7'b1110000));
            end else begin
                check("scan_hi_sel", 8'(sel), 8'h02);
                check("scan_hi_seg", 8'(seg), 8'(7'b1111110));
                check("scan_hi_blk", 8'(seg_b), 8'h00);
            end
        end

        repeat (600) begin
            @(posedge clk); #2;
            e       = $urandom_range(0, 3) != 0;
            u       = 1'($urandom);
            ld      = $urandom_range(0, 19) == 0;
            ld_val  = 8'($urandom);
            div_rst = $urandom_range(0, 29) == 0;
            rst     = $urandom_range(0, 99) == 0;
        end
        @(posedge clk); #2;
        rst = 1'b0; div_rst = 1'b0; ld = 1'b0; e = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
